aes_ext_bus_responder: RTL
==========================

Name: aes_ext_bus_responder

Overview:
- Responder (slave) end of the 128-bit external-bus interface: address[5:0], byte_enable[15:0], read, write, write_data, acknowledge, read_data.
- Accepts single-outstanding read/write transfers from a bus initiator and holds the AES operand and result registers.
- Drives key, plaintext and a start pulse into the AES core, and captures its result on completion.
- Used as the FPGA-side target for HPS/bridge traffic, and as the bench model of the far end of the bridge interface.

Parameters:
- WAIT_STATES, 1, extra cycles inserted between request capture and acknowledge (0..15).
- ADDR_W, 6, byte address width; word index = address[5:4], address[3:0] ignored.
- DATA_W, 128, data width; byte_enable width = DATA_W/8.

Ports:
- clk_clk  in  1  single clock, all logic rising-edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  byte address of transfer.
- byte_enable  in  DATA_W/8  write lane enables; bit i covers write_data[8i+7:8i].
- read  in  1  read request, held by initiator until acknowledge.
- write  in  1  write request, held by initiator until acknowledge.
- write_data  in  DATA_W  write payload.
- acknowledge  out  1  one-cycle transfer completion.
- read_data  out  DATA_W  valid only while acknowledge=1.
- aes_key  out  128  KEY register.
- aes_din  out  128  DIN register.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_busy  in  1  core busy.
- aes_done  in  1  one-cycle result-valid pulse.
- aes_dout  in  128  core result.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM to IDLE. Applies immediately and asynchronously. A transfer in flight is dropped with no acknowledge; the initiator must reissue it.
- FSM IDLE/WAIT/ACK.
  - IDLE: on read|write, capture address, byte_enable, write_data and direction. Go to WAIT, or to ACK if WAIT_STATES=0.
  - WAIT: 4-bit counter runs WAIT_STATES cycles, then goes to ACK.
  - ACK: acknowledge=1 for exactly one cycle, then unconditionally back to IDLE. The request visible during ACK is the same transfer and is never re-sampled.
- Latency: request sampled at edge N -> acknowledge high in cycle N+1+WAIT_STATES. Back-to-back transfers are accepted from the first IDLE cycle.
- read and write both high: acknowledged normally, no register change, read_data=0.
- Writes commit at the ACK-cycle edge, per byte lane.
- Read data is the register value in the ACK cycle. read_data returns to 0 after ACK.
- Register map (word index):
  - 0 KEY: RW.
  - 1 DIN: RW.
  - 2 DOUT: RO. Writes are ignored.
  - 3 CTRL:
    - bit0 START: write-1 with byte_enable[0]. If aes_busy=0, aes_start pulses in the cycle after commit. If aes_busy=1, no pulse and ERR is set. Reads 0.
    - bit1 DONE: W1C.
    - bit2 ERR: W1C.
    - bit3 IRQ_EN: RW.
    - bit4 BUSY: RO, mirrors aes_busy.
    - Other bits read 0.
- Any write to KEY or DIN while aes_busy=1 is discarded and sets ERR. The acknowledge is still given.
- aes_done=1: DOUT <= aes_dout and DONE <= 1.
  - A W1C of DONE in the same cycle loses; the set wins.
  - A DOUT read committing in the same cycle returns the old value.
- irq is registered DONE&IRQ_EN, so it lags by one cycle.

Test Plan:
- Reset, WAIT_STATES=1; write KEY=0x000102030405060708090A0B0C0D0E0F, be=0xFFFF -> acknowledge high exactly 2 cycles after request sample, one cycle wide; read addr 0x00 returns the same value.
- Write DIN=all-ones, be=0xFFFF; then write DIN=0, be=0x000F -> read gives 0xFFFF...FFFF_FFFF_0000_0000 (low 4 bytes cleared).
- Write CTRL=0x9 (IRQ_EN, START) with aes_busy=0 -> single aes_start pulse. Drive aes_done with aes_dout=0x3925841D02DC09FBDC118597196A0B32 -> DOUT reads that value, CTRL reads 0x0A, irq=1 one cycle later. Write CTRL=0x0A -> DONE cleared, irq=0.
- START or DIN write with aes_busy=1 -> no aes_start, DIN unchanged, CTRL bit2=1; W1C 0x4 clears it.
- aes_done coincident with a DONE W1C commit -> DONE stays 1. WAIT_STATES=0 -> ack 1 cycle after request. Assert reset_reset_n=0 during WAIT -> no acknowledge, registers 0; the reissued transfer completes.

Source files
------------

// File: rtl/aes_ext_bus_responder.sv
// External-bus responder holding AES key/plaintext/result registers.
// Single outstanding transfer; IDLE -> WAIT -> ACK handshake.
module aes_ext_bus_responder #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 128
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byte_enable,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   write_data,
    output logic                acknowledge,
    output logic [DATA_W-1:0]   read_data,
    output logic [127:0]        aes_key,
    output logic [127:0]        aes_din,
    output logic                aes_start,
    input  logic                aes_busy,
    input  logic                aes_done,
    input  logic [127:0]        aes_dout,
    output logic                irq
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state, state_n;

    logic [3:0]        wcnt;
    logic              req_rd;
    logic              req_wr;
    logic [1:0]        req_idx;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wd;

    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] dout_q;
    logic              done_q;
    logic              err_q;
    logic              ien_q;
    logic              commit;
    logic [DATA_W-1:0] ctrl_rd;
    logic              addr_unused;

    assign addr_unused = ^address[ADDR_W-3:0];

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wd,
        input logic [BE_W-1:0]   be
    );
        lane_merge = old;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) lane_merge[8*i +: 8] = wd[8*i +: 8];
        end
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            req_rd  <= 1'b0;
            req_wr  <= 1'b0;
            req_idx <= '0;
            req_be  <= '0;
            req_wd  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= (state == S_WAIT) ? wcnt + 4'd1 : 4'd0;
            if (state == S_IDLE && (read || write)) begin
                req_rd  <= read;
                req_wr  <= write;
                req_idx <= address[ADDR_W-1:ADDR_W-2];
                req_be  <= byte_enable;
                req_wd  <= write_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (read || write)
                    state_n = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == WS_LAST) state_n = S_ACK;
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign acknowledge = (state == S_ACK);
    assign commit      = acknowledge && req_wr && !req_rd;

    // Simultaneous read+write is acknowledged but returns zero.
    always_comb begin
        ctrl_rd      = '0;
        ctrl_rd[4:0] = {aes_busy, ien_q, err_q, done_q, 1'b0};
        read_data    = '0;
        if (acknowledge && req_rd && !req_wr) begin
            unique case (req_idx)
                2'd0: read_data = key_q;
                2'd1: read_data = din_q;
                2'd2: read_data = dout_q;
                2'd3: read_data = ctrl_rd;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ien_q     <= 1'b0;
            aes_start <= 1'b0;
            irq       <= 1'b0;
        end else begin
            aes_start <= 1'b0;
            irq       <= done_q && ien_q;
            if (aes_done) begin
                dout_q <= aes_dout;
                done_q <= 1'b1;
            end
            if (commit) begin
                unique case (req_idx)
                    2'd0: begin
                        if (aes_busy) err_q <= 1'b1;
                        else key_q <= lane_merge(key_q, req_wd, req_be);
                    end
                    2'd1: begin
                        if (aes_busy) err_q <= 1'b1;
                        else din_q <= lane_merge(din_q, req_wd, req_be);
                    end
                    2'd2: ;
                    2'd3: begin
                        if (req_be[0]) begin
                            ien_q <= req_wd[3];
                            if (req_wd[2]) err_q <= 1'b0;
                            if (req_wd[1] && !aes_done) done_q <= 1'b0;
                            // a rejected start sets ERR even if cleared here
                            if (req_wd[0]) begin
                                if (aes_busy) err_q <= 1'b1;
                                else aes_start <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign aes_key = key_q;
    assign aes_din = din_q;

endmodule
